// File: rtl/skid_buffer.sv
// Two-entry elastic buffer with fully registered valid/ready/count outputs.
// out_data is the head (main) register; skid holds the second word.
module skid_buffer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] skid;
  logic [WIDTH-1:0] main_nx;
  logic [WIDTH-1:0] skid_nx;
  logic [1:0]       count_nx;
  logic             it;
  logic             ot;

  assign it = in_valid & in_ready;
  assign ot = out_valid & out_ready;

  always_comb begin
    state_nx = state;
    main_nx  = out_data;
    skid_nx  = skid;
    count_nx = 2'd0;
    unique case (state)
      EMPTY: begin
        if (it) begin
          main_nx  = in_data;
          state_nx = ONE;
        end
      end
      ONE: begin
        if (it && ot) begin
          main_nx = in_data;
        end else if (it) begin
          skid_nx  = in_data;
          state_nx = TWO;
        end else if (ot) begin
          state_nx = EMPTY;
        end
      end
      TWO: begin
        if (ot) begin
          main_nx  = skid;
          state_nx = ONE;
        end
      end
      default: state_nx = EMPTY;
    endcase
    unique case (state_nx)
      ONE:     count_nx = 2'd1;
      TWO:     count_nx = 2'd2;
      default: count_nx = 2'd0;
    endcase
  end

  // Control outputs are loaded from next state so none depends on out_ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= EMPTY;
      out_data  <= '0;
      skid      <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      count     <= 2'd0;
    end else begin
      state     <= state_nx;
      out_data  <= main_nx;
      skid      <= skid_nx;
      in_ready  <= (state_nx != TWO);
      out_valid <= (state_nx != EMPTY);
      count     <= count_nx;
    end
  end

endmodule
